// File: rtl/iir_filter_pkg.sv
// Shared constants-free helpers for the multi-channel EMA filter: channel-width
// derivation and the per-sample update/rounding arithmetic used by RTL and bench.
package iir_filter_pkg;

    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // s' = s + ((x<<<frac) - s) >>> k, or x<<<frac on clear; widened to 64 bits so d never overflows
    function automatic longint iir_next(input longint s, input longint x,
                                        input int unsigned k, input logic clear,
                                        input int unsigned frac);
        longint x_e;
        longint d;
        int unsigned k_c;
        x_e = x <<< frac;
        d   = x_e - s;
        k_c = (k > 32'd62) ? 32'd62 : k;
        if (clear) begin
            return x_e;
        end
        return s + (d >>> k_c);
    endfunction

    function automatic longint iir_round(input longint s, input int unsigned frac);
        if (frac == 32'd0) begin
            return s;
        end
        return (s + (64'sd1 <<< (frac - 32'd1))) >>> frac;
    endfunction

endpackage

// File: rtl/iir_filter_mc_if.sv
// Sample/result bus of the filter; master drives samples, slave returns results.
interface iir_filter_mc_if #(
    parameter int WIDTH   = 16,
    parameter int CH_W    = 2,
    parameter int SHIFT_W = 4
);
    logic                    in_valid;
    logic [CH_W-1:0]         in_channel;
    logic signed [WIDTH-1:0] in_sample;
    logic [SHIFT_W-1:0]      in_shift;
    logic                    in_clear;
    logic                    out_valid;
    logic [CH_W-1:0]         out_channel;
    logic signed [WIDTH-1:0] out_sample;

    modport master (
        output in_valid, in_channel, in_sample, in_shift, in_clear,
        input  out_valid, out_channel, out_sample
    );

    modport slave (
        input  in_valid, in_channel, in_sample, in_shift, in_clear,
        output out_valid, out_channel, out_sample
    );
endinterface

// File: rtl/iir_filter_chk.sv
// Simulation checker: each new state lies between old state and scaled sample,
// and its rounded output fits the sample width.
module iir_filter_chk
    import iir_filter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 4
) (
    input logic                          clk,
    input logic                          reset,
    input logic                          valid,
    input logic signed [WIDTH+FRAC-1:0]  state,
    input logic signed [WIDTH+FRAC-1:0]  s_next,
    input logic signed [WIDTH-1:0]       sample
);
    longint x_e_s;
    longint lo_s;
    longint hi_s;
    longint y_s;
    logic   bound_ok_s;

    // bound evaluation for the sample currently in the update stage
    always_comb begin
        x_e_s      = longint'(sample) <<< FRAC;
        lo_s       = (x_e_s < longint'(state)) ? x_e_s : longint'(state);
        hi_s       = (x_e_s < longint'(state)) ? longint'(state) : x_e_s;
        y_s        = iir_round(longint'(s_next), FRAC);
        bound_ok_s = (longint'(s_next) >= lo_s) && (longint'(s_next) <= hi_s)
                     && (y_s >= -(64'sd1 <<< (WIDTH - 1)))
                     && (y_s < (64'sd1 <<< (WIDTH - 1)));
    end

    a_state_bound: assert property (@(posedge clk) disable iff (reset) valid |-> bound_ok_s);
endmodule

// File: rtl/iir_state_bank.sv
// Per-channel filter state register file: one combinational read port with
// same-cycle write-to-read forwarding, one write port.
module iir_state_bank #(
    parameter int CHANNELS = 4,
    parameter int DW       = 20,
    parameter int CH_W     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CH_W-1:0]      rd_addr,
    output logic signed [DW-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [CH_W-1:0]      wr_addr,
    input  logic signed [DW-1:0] wr_data
);
    logic signed [DW-1:0] mem_r [CHANNELS];

    // state storage, written by the update stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                mem_r[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_en && (wr_addr == CH_W'(c))) begin
                    mem_r[c] <= wr_data;
                end
            end
        end
    end

    // read mux; out-of-range addresses read zero, an in-progress write wins
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            rd_data = (rd_addr == CH_W'(c)) ? mem_r[c] : rd_data;
        end
        rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : rd_data;
    end
endmodule

// File: rtl/iir_filter_mc.sv
// Time-multiplexed first-order low-pass filter: stage 1 captures the sample and
// its channel state, stage 2 updates the state and registers the rounded result.
module iir_filter_mc
    import iir_filter_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int FRAC     = 4,
    parameter int SHIFT_W  = 4
) (
    input logic            clk,
    input logic            reset,
    iir_filter_mc_if.slave bus
);
    localparam int CH_W = clog2_min1(CHANNELS);
    localparam int SW   = WIDTH + FRAC;

    logic                    accept_s;
    logic signed [SW-1:0]    rd_state_s;
    logic signed [SW-1:0]    s_next_s;
    logic signed [WIDTH-1:0] y_s;

    logic                    s1_valid_r;
    logic [CH_W-1:0]         s1_channel_r;
    logic signed [WIDTH-1:0] s1_sample_r;
    logic [SHIFT_W-1:0]      s1_shift_r;
    logic                    s1_clear_r;
    logic signed [SW-1:0]    s1_state_r;

    logic                    out_valid_r;
    logic [CH_W-1:0]         out_channel_r;
    logic signed [WIDTH-1:0] out_sample_r;

    assign accept_s = bus.in_valid && ({1'b0, bus.in_channel} < (CH_W + 1)'(CHANNELS));

    // the stage-2 write is forwarded here so back-to-back samples on one channel chain correctly
    iir_state_bank #(
        .CHANNELS (CHANNELS),
        .DW       (SW),
        .CH_W     (CH_W)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (bus.in_channel),
        .rd_data (rd_state_s),
        .wr_en   (s1_valid_r),
        .wr_addr (s1_channel_r),
        .wr_data (s_next_s)
    );

    // stage 1: capture accepted sample with its current channel state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r   <= 1'b0;
            s1_channel_r <= '0;
            s1_sample_r  <= '0;
            s1_shift_r   <= '0;
            s1_clear_r   <= 1'b0;
            s1_state_r   <= '0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_channel_r <= bus.in_channel;
                s1_sample_r  <= bus.in_sample;
                s1_shift_r   <= bus.in_shift;
                s1_clear_r   <= bus.in_clear;
                s1_state_r   <= rd_state_s;
            end
        end
    end

    // update datapath
    always_comb begin
        s_next_s = SW'(iir_next(longint'(s1_state_r), longint'(s1_sample_r),
                                32'(s1_shift_r), s1_clear_r, FRAC));
        y_s      = WIDTH'(iir_round(longint'(s_next_s), FRAC));
    end

    // stage 2: result registers, held while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r   <= 1'b0;
            out_channel_r <= '0;
            out_sample_r  <= '0;
        end else begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_channel_r <= s1_channel_r;
                out_sample_r  <= y_s;
            end
        end
    end

    assign bus.out_valid   = out_valid_r;
    assign bus.out_channel = out_channel_r;
    assign bus.out_sample  = out_sample_r;

    iir_filter_chk #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_chk (
        .clk    (clk),
        .reset  (reset),
        .valid  (s1_valid_r),
        .state  (s1_state_r),
        .s_next (s_next_s),
        .sample (s1_sample_r)
    );
endmodule
